// File: rtl/ram_arbiter.sv
// Two-client round-robin arbiter that serialises read/write transactions
// onto a single-port RAM and returns read data through a req/ack handshake.
module ram_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_rd_wr,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_ip,
  input  logic [DW-1:0] ram_op
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic in_access;
  logic on_bus;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the client that was not served last wins; otherwise the sole requester.
          owner_d      = (req0 && req1) ? ~last_owner_q : req1;
          last_owner_d = owner_d;
          we_d         = owner_d ? we1    : we0;
          addr_d       = owner_d ? addr1  : addr0;
          wdata_d      = owner_d ? wdata1 : wdata0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          rdata_d = ram_op;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode registered state only, so req* never reaches the RAM combinationally.
  always_comb begin
    in_access   = (state_q == ACCESS);
    on_bus      = (state_q == ACCESS) || (state_q == WAIT);
    gnt0        = in_access && !owner_q;
    gnt1        = in_access && owner_q;
    ack0        = (state_q == DONE) && !owner_q;
    ack1        = (state_q == DONE) && owner_q;
    busy        = (state_q != IDLE);
    ram_rd_wr   = !(in_access && we_q);
    ram_address = on_bus ? addr_q : '0;
    ram_ip      = on_bus ? wdata_q : '0;
    rdata       = rdata_q;
  end

endmodule
